// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared program/data memory between the CPU (fixed priority) and a loader port.
// The loader steals idle CPU cycles and forces a one-cycle CPU freeze if it is starved too long.
module mem_port_arbiter #(
    parameter int unsigned AW       = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_hold,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_ack,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] WaitLast = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StForce,
        StAck
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          hold_we_q, hold_we_d;
    logic [AW-1:0] hold_addr_q, hold_addr_d;
    logic [DW-1:0] hold_wdata_q, hold_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          cpu_busy;
    logic          steal;
    logic          latch;

    assign cpu_busy  = cpu_read | cpu_write;
    assign cpu_rdata = mem_rdata;
    assign ld_rdata  = rdata_q;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        hold_we_d    = hold_we_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        rdata_d      = rdata_q;
        mem_read     = cpu_read;
        mem_write    = cpu_write;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        cpu_hold     = 1'b0;
        ld_ack       = 1'b0;
        steal        = 1'b0;
        latch        = 1'b0;

        unique case (state_q)
            StIdle: begin
                latch = ld_req;
                if (ld_req) state_d = StPend;
            end
            StPend: begin
                if (!cpu_busy) begin
                    steal   = 1'b1;
                    state_d = StAck;
                end else if (wait_q == WaitLast) begin
                    state_d = StForce;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StForce: begin
                // CPU is frozen, so its strobes are ignored this cycle
                cpu_hold = 1'b1;
                steal    = 1'b1;
                state_d  = StAck;
            end
            StAck: begin
                ld_ack  = 1'b1;
                latch   = ld_req;
                state_d = ld_req ? StPend : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (steal) begin
            mem_read  = ~hold_we_q;
            mem_write = hold_we_q;
            mem_addr  = hold_addr_q;
            mem_wdata = hold_wdata_q;
            if (!hold_we_q) rdata_d = mem_rdata;
        end

        if (latch) begin
            hold_we_d    = ld_we;
            hold_addr_d  = ld_addr;
            hold_wdata_d = ld_wdata;
            wait_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule
